// File: rtl/glbl_dmem.sv
// glbl_dmem: byte-addressed little-endian RV32I data memory with registered loads and range stall
module glbl_dmem #(
  parameter int          mem_size = 4096,
  parameter logic [63:0] inst_LB  = 64'h1 << 10,
  parameter logic [63:0] inst_LH  = 64'h1 << 11,
  parameter logic [63:0] inst_LW  = 64'h1 << 12,
  parameter logic [63:0] inst_LBU = 64'h1 << 13,
  parameter logic [63:0] inst_LHU = 64'h1 << 14,
  parameter logic [63:0] inst_SB  = 64'h1 << 15,
  parameter logic [63:0] inst_SH  = 64'h1 << 16,
  parameter logic [63:0] inst_SW  = 64'h1 << 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] Single_Instruction,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic [31:0] loadData_w,
  output logic        stall_mem_not_avalible,
  output logic        load_into_reg,
  input  logic [31:0] Cycle_count
);
  localparam int aw = $clog2(mem_size);
  logic [7:0] mem [mem_size] = '{default: 8'h00};
  logic lb, lh, lw, lbu, lhu, sb, sh, sw, ld, st;
  logic [1:0] last;
  logic [31:0] a, rdata;
  logic [32:0] top;
  logic [aw-1:0] idx;
  logic [7:0] b0, b1, b2, b3;
  logic unused;
  assign unused = ^Cycle_count;
  always_comb begin
    lb  = Single_Instruction == inst_LB;
    lh  = Single_Instruction == inst_LH;
    lw  = Single_Instruction == inst_LW;
    lbu = Single_Instruction == inst_LBU;
    lhu = Single_Instruction == inst_LHU;
    sb  = Single_Instruction == inst_SB;
    sh  = Single_Instruction == inst_SH;
    sw  = Single_Instruction == inst_SW;
    ld  = lb | lh | lw | lbu | lhu;
    st  = sb | sh | sw;
    last = (lw | sw) ? 2'd3 : (lh | lhu | sh) ? 2'd1 : 2'd0;
    a = address & ~{30'b0, last};
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    top = {1'b0, a} + {31'b0, last};
    stall_mem_not_avalible = (ld | st) && top >= 33'(mem_size);
    idx = a[aw-1:0];
    b0 = mem[idx];
    b1 = mem[idx + aw'(1)];
    b2 = mem[idx + aw'(2)];
    b3 = mem[idx + aw'(3)];
    rdata = lb  ? {{24{b0[7]}}, b0} :
            lbu ? {24'b0, b0} :
            lh  ? {{16{b1[7]}}, b1, b0} :
            lhu ? {16'b0, b1, b0} : {b3, b2, b1, b0};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      loadData_w    <= '0;
      load_into_reg <= 1'b0;
    end else begin
      load_into_reg <= ld & ~stall_mem_not_avalible;
      if (ld & ~stall_mem_not_avalible) loadData_w <= rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && st && !stall_mem_not_avalible) begin
      mem[idx] <= storeData[7:0];
      if (sh | sw) mem[idx + aw'(1)] <= storeData[15:8];
      if (sw) begin
        mem[idx + aw'(2)] <= storeData[23:16];
        mem[idx + aw'(3)] <= storeData[31:24];
      end
    end
  end
endmodule

// File: tb/tb_glbl_dmem.sv
// tb_glbl_dmem: directed and random load/store traffic checked against a byte-array model
module tb_glbl_dmem;
  localparam int MEM = 4096;
  localparam int LB = 0, LH = 1, LW = 2, LBU = 3, LHU = 4, SB = 5, SH = 6, SW = 7, NOP = 8;
  logic clk = 0, reset = 1;
  logic [63:0] instr = '0;
  logic [31:0] address = '0, store_data = '0, cycle_count = '0;
  logic [31:0] ld_w;
  logic stall, lir;
  logic [7:0] mm [MEM];
  logic [31:0] exp_ld = '0;
  int n_chk = 0, n_err = 0;

  glbl_dmem dut (
    .clk(clk), .reset(reset), .Single_Instruction(instr), .address(address),
    .storeData(store_data), .loadData_w(ld_w), .stall_mem_not_avalible(stall),
    .load_into_reg(lir), .Cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] nop_pat();
    int r = $urandom_range(0, 2);
    return r == 0 ? 64'h0 : r == 1 ? (64'h1 << 10) | (64'h1 << 17) : 64'h1 << $urandom_range(18, 63);
  endfunction

  task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] d);
    int sz;
    longint a, raw;
    bit ok;
    sz = op == NOP ? 0 : (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    a = longint'(addr);
    if (sz > 0) a = a - a % sz;
    ok = sz > 0 && a + sz <= MEM;
    @(negedge clk);
    reset = 0;
    instr = op == NOP ? nop_pat() : 64'h1 << (10 + op);
    address = addr;
    store_data = d;
    cycle_count = cycle_count + 1;
    #1 check("stall", 32'(stall), 32'(sz > 0 && !ok));
    @(posedge clk);
    #1;
    if (ok && op <= LHU) begin
      raw = 0;
      for (int k = sz - 1; k >= 0; k--) raw = raw * 256 + longint'(mm[int'(a) + k]);
      if ((op == LB && raw >= 128) || (op == LH && raw >= 32768)) raw -= longint'(1) << (8 * sz);
      exp_ld = 32'(raw);
    end
    check("lir", 32'(lir), 32'(ok && op <= LHU));
    check("ld", ld_w, exp_ld);
    if (ok && op >= SB)
      for (int k = 0; k < sz; k++) mm[int'(a) + k] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  task automatic rst_op(input int op, input logic [31:0] addr, input logic [31:0] d);
    @(negedge clk);
    reset = 1;
    instr = 64'h1 << (10 + op);
    address = addr;
    store_data = d;
    @(posedge clk);
    #1;
    exp_ld = '0;
    check("rst_ld", ld_w, 32'h0);
    check("rst_lir", 32'(lir), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) mm[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("init_ld", ld_w, 32'h0);
    check("init_lir", 32'(lir), 32'h0);
    check("init_stall", 32'(stall), 32'h0);
    do_op(SB, 32'h4, 32'hAA);
    do_op(SB, 32'h8, 32'hAA);
    do_op(SB, 32'hC, 32'hAA);
    do_op(LH, 32'h4, 0);  check("lh4", ld_w, 32'h000000AA);
    do_op(NOP, 0, 0);     check("lir_pulse", 32'(lir), 32'h0);
    do_op(LB, 32'h4, 0);  check("lb4", ld_w, 32'hFFFFFFAA);
    do_op(LBU, 32'h4, 0); check("lbu4", ld_w, 32'h000000AA);
    do_op(LW, 32'hC, 0);  check("lwc", ld_w, 32'h000000AA);
    do_op(SW, 32'h8, 32'hDEADBEEF);
    do_op(LW, 32'h8, 0);  check("lw8", ld_w, 32'hDEADBEEF);
    do_op(LHU, 32'hA, 0); check("lhua", ld_w, 32'h0000DEAD);
    do_op(LH, 32'hA, 0);  check("lha", ld_w, 32'hFFFFDEAD);
    do_op(LB, 32'hB, 0);  check("lbb", ld_w, 32'hFFFFFFDE);
    do_op(LW, 32'h9, 0);  check("lw_misalign", ld_w, 32'hDEADBEEF);
    do_op(SB, 32'h4, 32'hAA);
    do_op(SH, 32'h6, 32'h0000BBCC);
    do_op(LW, 32'h4, 0);  check("lw4", ld_w, 32'hBBCC00AA);
    do_op(LW, 32'h8, 0);  check("lw8_kept", ld_w, 32'hDEADBEEF);
    do_op(SW, 32'h1000, 32'h12345678);
    do_op(LW, 32'h0FFC, 0); check("lw_top", ld_w, 32'h0);
    do_op(LW, 32'h0FFF, 0);
    do_op(LH, 32'h1000, 0);
    do_op(SW, 32'hFFFFFFFF, 32'h11111111);
    rst_op(SW, 32'h20, 32'hCAFEF00D);
    do_op(LW, 32'h20, 0); check("rst_nowrite", ld_w, 32'h0);
    rst_op(LW, 32'h8, 0);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      logic [31:0] ad = r < 6 ? 32'($urandom_range(0, 63)) : r < 9 ? 32'($urandom_range(4088, 4103)) : $urandom;
      if ($urandom_range(0, 39) == 0) rst_op($urandom_range(0, 7), ad, $urandom);
      else do_op($urandom_range(0, 8), ad, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
